// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry layout for the fetch-to-decode instruction queue.
// An entry is one fetched {instr, pc, incPC} triple.
package fetch_queue_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h5400_0000;

    // Entry layout, most significant field first.
    localparam int ENTRY_W   = 3 * WORD_W;
    localparam int INSTR_LSB = 2 * WORD_W;
    localparam int PC_LSB    = WORD_W;
    localparam int INCPC_LSB = 0;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] incpc;
    } entry_t;

    function automatic entry_t pack_entry(logic [WORD_W-1:0] instr,
                                          logic [WORD_W-1:0] pc,
                                          logic [WORD_W-1:0] incpc);
        entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.incpc = incpc;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle between fetch/decode (master) and the fetch queue (slave).
// Handshake: a push is taken when push & (~full | accepted pop); a pop is taken when pop & out_valid.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    import fetch_queue_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic              flush;
    logic              push;
    logic [WORD_W-1:0] in_instr;
    logic [WORD_W-1:0] in_pc;
    logic [WORD_W-1:0] in_incPC;
    logic              pop;
    logic              out_valid;
    logic [WORD_W-1:0] out_instr;
    logic [WORD_W-1:0] out_pc;
    logic [WORD_W-1:0] out_incPC;
    logic              full;
    logic              empty;
    logic [AW:0]       count;

    modport master (
        output flush, push, in_instr, in_pc, in_incPC, pop,
        input  out_valid, out_instr, out_pc, out_incPC, full, empty, count
    );

    modport slave (
        input  flush, push, in_instr, in_pc, in_incPC, pop,
        output out_valid, out_instr, out_pc, out_incPC, full, empty, count
    );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read, no reset.
module fq_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  entry_t        wdata_i,
    input  logic [AW-1:0] raddr_i,
    output entry_t        rdata_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode; flush discards the wrong-path contents.
// Pointers, occupancy and output masking live here; storage is in fq_mem.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic   empty, full, pop_ok, push_ok;
    entry_t head;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // A full queue still takes a push when the head leaves in the same cycle.
    assign pop_ok  = bus.pop & ~empty;
    assign push_ok = bus.push & (~full | pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
            else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_ok & ~bus.flush & ~rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (pack_entry(bus.in_instr, bus.in_pc, bus.in_incPC)),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Stale storage is never shown: an empty queue presents a NOP with zero PCs.
    assign bus.out_valid = ~empty;
    assign bus.out_instr = empty ? NOP_INSTR : head.instr;
    assign bus.out_pc    = empty ? '0 : head.pc;
    assign bus.out_incPC = empty ? '0 : head.incpc;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: entries in arrival order, head at index 0
    entry_t model_q[$];

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit f, input bit pu, input bit po, input entry_t e);
        bit pop_take;
        bit push_take;
        if (r || f) begin
            model_q.delete();
        end else begin
            pop_take  = po && (model_q.size() > 0);
            push_take = pu && ((model_q.size() < DEPTH) || pop_take);
            if (pop_take)  void'(model_q.pop_front());
            if (push_take) model_q.push_back(e);
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, "_count"}, 32'(bus.count), 32'(sz));
        chk({tag, "_empty"}, 32'(bus.empty), 32'(sz == 0));
        chk({tag, "_full"},  32'(bus.full),  32'(sz == DEPTH));
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(sz != 0));
        if (sz == 0) begin
            chk({tag, "_instr"}, bus.out_instr, NOP_INSTR);
            chk({tag, "_pc"},    bus.out_pc,    32'h0);
            chk({tag, "_incpc"}, bus.out_incPC, 32'h0);
        end else begin
            chk({tag, "_instr"}, bus.out_instr, model_q[0].instr);
            chk({tag, "_pc"},    bus.out_pc,    model_q[0].pc);
            chk({tag, "_incpc"}, bus.out_incPC, model_q[0].incpc);
        end
    endtask

    // driver: apply one cycle of inputs, advance the model, check after the edge
    task automatic step(input string tag, input bit r, input bit f, input bit pu,
                        input bit po, input logic [31:0] pc);
        entry_t e;
        e.instr = $urandom();
        e.pc    = pc;
        e.incpc = pc + 32'd4;
        rst          = r;
        bus.flush    = f;
        bus.push     = pu;
        bus.pop      = po;
        bus.in_instr = e.instr;
        bus.in_pc    = e.pc;
        bus.in_incPC = e.incpc;
        @(posedge clk);
        model_update(r, f, pu, po, e);
        #1;
        check_model(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.in_instr = '0;
        bus.in_pc = '0;
        bus.in_incPC = '0;

        // reset for two cycles with push held high
        step("rst0", 1, 0, 1, 0, 32'h80);
        step("rst1", 1, 0, 1, 0, 32'h84);
        chk("rst_out_instr", bus.out_instr, 32'h5400_0000);
        chk("rst_out_pc", bus.out_pc, 32'h0);

        // fill to full, drop the fifth push, drain in order
        for (int i = 0; i < 4; i++) step("fill", 0, 0, 1, 0, 32'h100 + 32'(4*i));
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_head_pc", bus.out_pc, 32'h100);
        chk("fill_head_incpc", bus.out_incPC, 32'h104);
        step("drop", 0, 0, 1, 0, 32'h110);
        chk("drop_head_pc", bus.out_pc, 32'h100);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", bus.out_pc, 32'h100 + 32'(4*i));
            step("drain", 0, 0, 0, 1, 32'h0);
        end

        // full with simultaneous push and pop, then wrap the pointers
        for (int i = 0; i < 4; i++) step("refill", 0, 0, 1, 0, 32'h100 + 32'(4*i));
        step("fullpp", 0, 0, 1, 1, 32'h110);
        chk("fullpp_count", 32'(bus.count), 32'd4);
        chk("fullpp_head", bus.out_pc, 32'h104);
        for (int i = 0; i < 8; i++) step("wrap", 0, 0, 1, 1, 32'h114 + 32'(4*i));
        for (int i = 0; i < 4; i++) begin
            chk("wrap_order", bus.out_pc, 32'h124 + 32'(4*i));
            step("wrapdrain", 0, 0, 0, 1, 32'h0);
        end

        // empty with push and pop together; pop on empty
        step("emptypp", 0, 0, 1, 1, 32'h200);
        chk("emptypp_count", 32'(bus.count), 32'd1);
        chk("emptypp_pc", bus.out_pc, 32'h200);
        step("pop_last", 0, 0, 0, 1, 32'h0);
        step("pop_empty", 0, 0, 0, 1, 32'h0);
        chk("pop_empty_count", 32'(bus.count), 32'd0);

        // flush with push and pop also asserted
        for (int i = 0; i < 3; i++) step("preflush", 0, 0, 1, 0, 32'h300 + 32'(4*i));
        chk("preflush_count", 32'(bus.count), 32'd3);
        step("flush", 0, 1, 1, 1, 32'h3FC);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        step("postflush", 0, 0, 1, 0, 32'h400);
        chk("postflush_pc", bus.out_pc, 32'h400);
        chk("postflush_valid", 32'(bus.out_valid), 32'd1);

        // randomized traffic including occasional flush and reset
        for (int i = 0; i < 2000; i++) begin
            step("rand",
                 ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1),
                 {$urandom_range(0, 32'h3FFF), 2'b00});
            chk("rand_count_range", 32'(bus.count <= 3'd4), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
